ysyx_24110015_lsu: RTL and testbench

- Load/store stage sitting directly downstream of the execute stage and upstream of writeback.
- Latches one execute result per valid/ready handshake and performs at most one memory access on a single-outstanding request/response bus.
- Handles byte-lane alignment, load sign/zero extension and misalignment/timeout faults.
- Presents a registered writeback packet to the writeback stage.

---
 rtl/ysyx_24110015_lsu.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_24110015_lsu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_lsu
//
// Load/store stage between execute and writeback. It accepts one execute
// result per in_valid/in_ready handshake and performs at most one access on
// a single-outstanding request/response bus. The stage handles byte-lane
// alignment for stores, sign/zero extension for loads, and raises
// access_fault for misaligned accesses, empty store masks, bus errors and
// response timeouts. The writeback packet is fully registered.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       execute-side handshake
//   alu_out                   memory address or ALU result
//   mem_wdata_i, mem_wmask_i  unshifted store data / byte mask
//   func3                     access size and signedness
//   MemRead, MemWrite         load / store (store wins if both are set)
//   RegWrite_i, wb_addr_i     destination register enable / index
//   zicsr_i, csr_rdata        CSR instruction / old CSR value
//   pc_next_i                 next PC, carried through to writeback
//   bus_req_*                 request channel (addr, wen, wdata, wstrb)
//   bus_rsp_*                 response channel (rdata, err)
//   out_valid / out_ready     writeback-side handshake
//   wb_data, RegWrite_o,
//   wb_addr_o, pc_next_o,
//   access_fault              registered writeback packet
// ---------------------------------------------------------------------------
module ysyx_24110015_lsu #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] RESET_PC = 32'h20000000
) (
  input  logic        clk,
  input  logic        rst,
  // execute side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wmask_i,
  input  logic [2:0]  func3,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        zicsr_i,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] pc_next_i,
  // memory bus
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rsp_err,
  // writeback side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic        RegWrite_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] pc_next_o,
  output logic        access_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] addr_q;      // full byte address of the pending access
  logic [2:0]  func3_q;
  logic        is_load_q;
  logic        regwrite_q;

  // Accept-time decode
  logic        is_mem;
  logic        misaligned;
  logic        accept_fault;

  // Response-time load extraction
  logic [31:0] rdata_sh;
  logic [31:0] load_data;

  assign in_ready      = (state == IDLE);
  assign bus_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);

  assign is_mem     = MemRead | MemWrite;
  assign misaligned = ((func3[1:0] == 2'b01) && alu_out[0]) ||
                      ((func3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
  // An empty store mask would produce a bus write with no lanes; treat it
  // as a fault instead of issuing a no-op transaction.
  assign accept_fault = misaligned || (MemWrite && (mem_wmask_i == 4'b0000));

  assign rdata_sh = bus_rdata >> {addr_q[1:0], 3'b000};

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    load_data = 32'h0;
    unique case (func3_q)
      3'b000:  load_data = {{24{rdata_sh[7]}},  rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_data = rdata_sh;
      3'b100:  load_data = {24'h0, rdata_sh[7:0]};
      3'b101:  load_data = {16'h0, rdata_sh[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  // NOTE: all state here is sequential, so only non-blocking assignments are
  // used; every reader in the same cycle sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 8'h0;
      addr_q       <= 32'h0;
      func3_q      <= 3'b000;
      is_load_q    <= 1'b0;
      regwrite_q   <= 1'b0;
      bus_addr     <= 32'h0;
      bus_wen      <= 1'b0;
      bus_wdata    <= 32'h0;
      bus_wstrb    <= 4'b0000;
      wb_data      <= 32'h0;
      RegWrite_o   <= 1'b0;
      wb_addr_o    <= 5'd0;
      pc_next_o    <= RESET_PC;
      access_fault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q       <= alu_out;
            func3_q      <= func3;
            is_load_q    <= MemRead & ~MemWrite;
            regwrite_q   <= RegWrite_i;
            wb_addr_o    <= wb_addr_i;
            pc_next_o    <= pc_next_i;
            // Non-load result is known now; a load overwrites it later.
            wb_data      <= zicsr_i ? csr_rdata : alu_out;
            RegWrite_o   <= RegWrite_i;
            access_fault <= 1'b0;
            bus_addr     <= {alu_out[31:2], 2'b00};
            bus_wen      <= MemWrite;
            bus_wdata    <= MemWrite ? (mem_wdata_i << {alu_out[1:0], 3'b000}) : 32'h0;
            bus_wstrb    <= MemWrite ? (mem_wmask_i << alu_out[1:0]) : 4'b0000;
            if (!is_mem) begin
              state <= DONE;
            end else if (accept_fault) begin
              wb_data      <= alu_out;
              RegWrite_o   <= 1'b0;
              access_fault <= 1'b1;
              state        <= DONE;
            end else begin
              RegWrite_o <= 1'b0;
              state      <= REQ;
            end
          end
        end

        // Request fields were registered at accept and are untouched here,
        // so they stay stable for as long as the bus stalls.
        REQ: begin
          if (bus_req_ready) begin
            wait_cnt <= 8'h0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (bus_rsp_valid) begin
            state <= DONE;
            if (bus_rsp_err) begin
              wb_data      <= addr_q;
              RegWrite_o   <= 1'b0;
              access_fault <= 1'b1;
            end else begin
              if (is_load_q) wb_data <= load_data;
              RegWrite_o <= regwrite_q;
            end
          end else if (wait_cnt + 8'd1 == TIMEOUT_C) begin
            wb_data      <= addr_q;
            RegWrite_o   <= 1'b0;
            access_fault <= 1'b1;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          // Returning to IDLE leaves one bubble before the next accept.
          if (out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
module tb_ysyx_24110015_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wmask_i;
  logic [2:0]  func3;
  logic        MemRead, MemWrite, RegWrite_i;
  logic [4:0]  wb_addr_i;
  logic        zicsr_i;
  logic [31:0] csr_rdata, pc_next_i;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_rsp_err;
  logic        out_valid, out_ready;
  logic [31:0] wb_data;
  logic        RegWrite_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] pc_next_o;
  logic        access_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_24110015_lsu #(.TIMEOUT(4), .RESET_PC(32'h20000000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
    .func3(func3), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite_i(RegWrite_i), .wb_addr_i(wb_addr_i), .zicsr_i(zicsr_i),
    .csr_rdata(csr_rdata), .pc_next_i(pc_next_i),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata), .bus_rsp_err(bus_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
    .RegWrite_o(RegWrite_o), .wb_addr_o(wb_addr_o), .pc_next_o(pc_next_o),
    .access_fault(access_fault)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [2:0]  f3;
    logic        rd, wr, rw, csr;
    logic [31:0] csr_data;
    logic [31:0] rdata;
    logic        err;
    logic        e_bus;
    logic [31:0] e_baddr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wb;
    logic        e_rw;
    logic        e_fault;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string name, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] wmask, input logic [2:0] f3, input logic rd, input logic wr,
    input logic rw, input logic csr, input logic [31:0] csr_data,
    input logic [31:0] rdata, input logic err, input logic e_bus,
    input logic [31:0] e_baddr, input logic e_wen, input logic [31:0] e_wdata,
    input logic [3:0] e_wstrb, input logic [31:0] e_wb, input logic e_rw,
    input logic e_fault);
    vec_t v;
    v.name = name; v.addr = addr; v.wdata = wdata; v.wmask = wmask; v.f3 = f3;
    v.rd = rd; v.wr = wr; v.rw = rw; v.csr = csr; v.csr_data = csr_data;
    v.rdata = rdata; v.err = err; v.e_bus = e_bus; v.e_baddr = e_baddr;
    v.e_wen = e_wen; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_wb = e_wb;
    v.e_rw = e_rw; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; alu_out = '0; mem_wdata_i = '0; mem_wmask_i = '0; func3 = '0;
    MemRead = 0; MemWrite = 0; RegWrite_i = 0; wb_addr_i = '0; zicsr_i = 0;
    csr_rdata = '0; pc_next_i = '0;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic [2:0] f3,
                       input logic rd, input logic wr, input logic rw,
                       input logic [4:0] wa, input logic [31:0] pc);
    alu_out = addr; mem_wdata_i = wdata; mem_wmask_i = wmask; func3 = f3;
    MemRead = rd; MemWrite = wr; RegWrite_i = rw; wb_addr_i = wa;
    zicsr_i = 0; csr_rdata = '0; pc_next_i = pc; in_valid = 1;
  endtask

  task automatic drain();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  // Accept one vector, service the bus if it asks, then check the packet.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    logic [4:0]  wa;
    logic [31:0] pc;
    wa = 5'(idx + 1);
    pc = 32'h80000000 + 32'(idx * 4);
    @(negedge clk);
    check({v.name, " in_ready"}, in_ready, 1'b1);
    drive(v.addr, v.wdata, v.wmask, v.f3, v.rd, v.wr, v.rw, wa, pc);
    zicsr_i = v.csr; csr_rdata = v.csr_data;
    @(negedge clk);
    idle_inputs();
    if (v.e_bus) begin
      cyc = 0;
      while (!bus_req_valid && cyc < 10) begin @(negedge clk); cyc++; end
      check({v.name, " bus_req_valid"}, bus_req_valid, 1'b1);
      check({v.name, " bus_addr"}, bus_addr, v.e_baddr);
      check({v.name, " bus_wen"}, bus_wen, v.e_wen);
      check({v.name, " bus_wdata"}, bus_wdata, v.e_wdata);
      check({v.name, " bus_wstrb"}, bus_wstrb, v.e_wstrb);
      bus_req_ready = 1;
      @(negedge clk);
      bus_req_ready = 0;
      bus_rsp_valid = 1; bus_rdata = v.rdata; bus_rsp_err = v.err;
      @(negedge clk);
      bus_rsp_valid = 0; bus_rdata = '0; bus_rsp_err = 0;
    end else begin
      check({v.name, " no bus_req_valid"}, bus_req_valid, 1'b0);
    end
    check({v.name, " out_valid"}, out_valid, 1'b1);
    check({v.name, " wb_data"}, wb_data, v.e_wb);
    check({v.name, " RegWrite_o"}, RegWrite_o, v.e_rw);
    check({v.name, " access_fault"}, access_fault, v.e_fault);
    check({v.name, " wb_addr_o"}, wb_addr_o, wa);
    check({v.name, " pc_next_o"}, pc_next_o, pc);
    drain();
    check({v.name, " back to idle"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] hold_wb;
    //               name         addr          wdata         mask     f3      rd wr rw csr csr_data       rdata         err bus baddr         wen wdata         strb     wb            rw flt
    vecs[0]  = mk("alu",        32'h00001234, 32'h0,        4'b0000, 3'b000, 0, 0, 1, 0, 32'h0,        32'h0,        0,  0,  32'h0,        0,  32'h0,        4'b0000, 32'h00001234, 1, 0);
    vecs[1]  = mk("csr",        32'h00000300, 32'h0,        4'b0000, 3'b001, 0, 0, 1, 1, 32'hCAFE0001, 32'h0,        0,  0,  32'h0,        0,  32'h0,        4'b0000, 32'hCAFE0001, 1, 0);
    vecs[2]  = mk("lb",         32'h80000003, 32'h0,        4'b0000, 3'b000, 1, 0, 1, 0, 32'h0,        32'h80FF0000, 0,  1,  32'h80000000, 0,  32'h0,        4'b0000, 32'hFFFFFF80, 1, 0);
    vecs[3]  = mk("lbu",        32'h80000003, 32'h0,        4'b0000, 3'b100, 1, 0, 1, 0, 32'h0,        32'h80FF0000, 0,  1,  32'h80000000, 0,  32'h0,        4'b0000, 32'h00000080, 1, 0);
    vecs[4]  = mk("lh",         32'h80000002, 32'h0,        4'b0000, 3'b001, 1, 0, 1, 0, 32'h0,        32'h80011234, 0,  1,  32'h80000000, 0,  32'h0,        4'b0000, 32'hFFFF8001, 1, 0);
    vecs[5]  = mk("lhu",        32'h10000000, 32'h0,        4'b0000, 3'b101, 1, 0, 1, 0, 32'h0,        32'h0000F00F, 0,  1,  32'h10000000, 0,  32'h0,        4'b0000, 32'h0000F00F, 1, 0);
    vecs[6]  = mk("lw",         32'h80000004, 32'h0,        4'b0000, 3'b010, 1, 0, 1, 0, 32'h0,        32'hDEADBEEF, 0,  1,  32'h80000004, 0,  32'h0,        4'b0000, 32'hDEADBEEF, 1, 0);
    vecs[7]  = mk("load f3=011",32'h80000000, 32'h0,        4'b0000, 3'b011, 1, 0, 1, 0, 32'h0,        32'hFFFFFFFF, 0,  1,  32'h80000000, 0,  32'h0,        4'b0000, 32'h00000000, 1, 0);
    vecs[8]  = mk("sw",         32'h80000008, 32'h11223344, 4'b1111, 3'b010, 0, 1, 0, 0, 32'h0,        32'h0,        0,  1,  32'h80000008, 1,  32'h11223344, 4'b1111, 32'h80000008, 0, 0);
    vecs[9]  = mk("sb",         32'h80000001, 32'h000000AB, 4'b0001, 3'b000, 0, 1, 0, 0, 32'h0,        32'h0,        0,  1,  32'h80000000, 1,  32'h0000AB00, 4'b0010, 32'h80000001, 0, 0);
    vecs[10] = mk("lw misalign",32'h80000002, 32'h0,        4'b0000, 3'b010, 1, 0, 1, 0, 32'h0,        32'h0,        0,  0,  32'h0,        0,  32'h0,        4'b0000, 32'h80000002, 0, 1);
    vecs[11] = mk("lh misalign",32'h80000001, 32'h0,        4'b0000, 3'b001, 1, 0, 1, 0, 32'h0,        32'h0,        0,  0,  32'h0,        0,  32'h0,        4'b0000, 32'h80000001, 0, 1);
    vecs[12] = mk("sw mask0",   32'h80000010, 32'h12345678, 4'b0000, 3'b010, 0, 1, 0, 0, 32'h0,        32'h0,        0,  0,  32'h0,        0,  32'h0,        4'b0000, 32'h80000010, 0, 1);
    vecs[13] = mk("lbu rsp_err",32'h80000021, 32'h0,        4'b0000, 3'b100, 1, 0, 1, 0, 32'h0,        32'h000000FF, 1,  1,  32'h80000020, 0,  32'h0,        4'b0000, 32'h80000021, 0, 1);
    vecs[14] = mk("rd+wr store",32'h80000000, 32'hA5A5A5A5, 4'b1111, 3'b010, 1, 1, 1, 0, 32'h0,        32'h0,        0,  1,  32'h80000000, 1,  32'hA5A5A5A5, 4'b1111, 32'h80000000, 1, 0);

    idle_inputs();
    out_ready = 0; bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = '0; bus_rsp_err = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset bus_req_valid", bus_req_valid, 1'b0);
    check("reset pc_next_o", pc_next_o, 32'h20000000);
    check("reset wb_data", wb_data, 32'h0);
    check("reset RegWrite_o", RegWrite_o, 1'b0);
    check("reset access_fault", access_fault, 1'b0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // sh with the request stalled for 3 cycles: fields must stay put.
    @(negedge clk);
    drive(32'h80000002, 32'h0000BEEF, 4'b0011, 3'b001, 0, 1, 0, 5'd9, 32'h80000100);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      check("stall bus_req_valid", bus_req_valid, 1'b1);
      check("stall bus_addr", bus_addr, 32'h80000000);
      check("stall bus_wen", bus_wen, 1'b1);
      check("stall bus_wstrb", bus_wstrb, 4'b1100);
      check("stall bus_wdata", bus_wdata, 32'hBEEF0000);
      @(negedge clk);
    end
    check("stall still requesting", bus_req_valid, 1'b1);
    bus_req_ready = 1;
    @(negedge clk);
    bus_req_ready = 0;
    check("stall req dropped in WAIT", bus_req_valid, 1'b0);
    bus_rsp_valid = 1;
    @(negedge clk);
    bus_rsp_valid = 0;
    check("stall out_valid", out_valid, 1'b1);
    check("stall access_fault", access_fault, 1'b0);
    drain();

    // Response never returns: fault after exactly 4 WAIT cycles.
    @(negedge clk);
    drive(32'h80000044, 32'h0, 4'b0000, 3'b010, 1, 0, 1, 5'd3, 32'h80000200);
    @(negedge clk);
    idle_inputs();
    bus_req_ready = 1;
    @(negedge clk);
    bus_req_ready = 0;
    n = 0;
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    check("timeout wait cycles", 32'(n), 32'd4);
    check("timeout out_valid", out_valid, 1'b1);
    check("timeout access_fault", access_fault, 1'b1);
    check("timeout RegWrite_o", RegWrite_o, 1'b0);
    check("timeout wb_data", wb_data, 32'h80000044);
    drain();

    // DONE held with out_ready low; a waiting input must not be taken early.
    @(negedge clk);
    drive(32'h00005555, 32'h0, 4'b0000, 3'b000, 0, 0, 1, 5'd7, 32'h80000300);
    @(negedge clk);
    alu_out = 32'h00006666; wb_addr_i = 5'd8; pc_next_i = 32'h80000304;
    for (int k = 0; k < 5; k++) begin
      check("hold out_valid", out_valid, 1'b1);
      check("hold in_ready", in_ready, 1'b0);
      check("hold wb_data", wb_data, 32'h00005555);
      check("hold wb_addr_o", wb_addr_o, 5'd7);
      @(negedge clk);
    end
    drain();
    check("bubble in_ready", in_ready, 1'b1);
    check("bubble out_valid", out_valid, 1'b0);
    @(negedge clk);
    idle_inputs();
    check("after bubble out_valid", out_valid, 1'b1);
    check("after bubble wb_data", wb_data, 32'h00006666);
    check("after bubble pc_next_o", pc_next_o, 32'h80000304);
    drain();

    // Reset while in WAIT, then a stray response in IDLE.
    @(negedge clk);
    drive(32'h80000040, 32'h0, 4'b0000, 3'b010, 1, 0, 1, 5'd4, 32'h80000400);
    @(negedge clk);
    idle_inputs();
    bus_req_ready = 1;
    @(negedge clk);
    bus_req_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst-wait in_ready", in_ready, 1'b1);
    check("rst-wait out_valid", out_valid, 1'b0);
    check("rst-wait bus_req_valid", bus_req_valid, 1'b0);
    check("rst-wait pc_next_o", pc_next_o, 32'h20000000);
    bus_rsp_valid = 1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_rsp_valid = 0;
    check("stray rsp out_valid", out_valid, 1'b0);
    check("stray rsp in_ready", in_ready, 1'b1);
    check("stray rsp wb_data", wb_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
